reg_scoreboard_decoder: RTL
===========================

# reg_scoreboard_decoder

Parametrised write-port decoder with per-register pending-write scoreboard for the pipelined CPU register file. Decodes the writeback destination into a one-hot register write-enable vector, with a hard-wired zero register. Tracks outstanding writes per register via small saturating counters. Raises a stall when an issuing instruction's sources have pending writes or its destination counter is full.

## Interface
- ADDR_W, 5, register address width; NREGS = 2**ADDR_W
- CNT_W, 2, pending-write counter width per register; CNT_MAX = 2**CNT_W-1
- ZERO_REG, NREGS-1, hard-wired zero register index; never written, never busy
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high; clears all state
- wb_en  in  1  writeback commit this cycle
- wb_addr  in  ADDR_W  writeback destination
- wr_onehot  out  NREGS  register-file write enables, combinational
- iss_en  in  1  issue request; reserves destination when accepted
- iss_dst  in  ADDR_W  issuing instruction's destination
- iss_src_a, iss_src_b  in  ADDR_W  issuing instruction's source registers
- stall  out  1  issue blocked this cycle, combinational
- busy  out  NREGS  per-register pending flag (count != 0), registered
- err  out  1  sticky underflow flag, registered

## Operation
- wr_onehot[i] = wb_en & (wb_addr == i) & (i != ZERO_REG); at most one bit set.
- Issue accepted (iss_fire) = iss_en & ~stall.
- stall = iss_en & (hazard_a | hazard_b | full_dst).
- hazard_x = src_x != ZERO_REG & count[src_x] != 0.
- full_dst = iss_dst != ZERO_REG & count[iss_dst] == CNT_MAX.
- Per-register update at clk edge:
  - inc = iss_fire & iss_dst == i; dec = wb_en & wb_addr == i.
  - inc & ~dec: count+1.
  - dec & ~inc: count-1; if count == 0, hold at 0 and set err.
  - inc & dec: unchanged.
  - Neither: unchanged.
- ZERO_REG counter stays 0; issue/writeback to it ignored, no err.
- err set only by underflow; cleared only by reset.
- No FSM: state is NREGS counters plus err.

## Timing
- Reset: all counts 0, busy all 0, err 0. wr_onehot and stall follow inputs combinationally, so all 0 when wb_en = iss_en = 0.
- Reset asserted mid-operation discards all pending counts at that edge. Same-edge issue/writeback are ignored.
- Accepted issue at edge N: busy[dst] = 1 after edge N. A dependent issue in cycle N+1 stalls.
- Writeback at edge M with count 1: busy clears after M.
- Same-cycle writeback and source read of that register: stall is asserted, unless the bypass below is enabled.
- stall depends on registered counts and current inputs only; no combinational path from wb_* to stall without the macro.

## Configuration
- SCOREBOARD_BYPASS_EN defined:
  - hazard_x is suppressed when wb_en & wb_addr == src_x & count[src_x] == 1. The register-file write-through path forwards that data.
  - full_dst is suppressed when wb_addr == iss_dst & wb_en.
- Undefined: no wb_* term in stall; pending writes stall until the cycle after writeback.

## Structure
- Package regfile_pkg:
  - ADDR_W default and ZERO_REG constant.
  - typedef logic [CNT_W-1:0] pend_cnt_t.
  - typedef logic [NREGS-1:0] reg_vec_t.
- Sub-module decoder_param (ADDR_W, enable → 2**ADDR_W one-hot, combinational). Instantiate once for writeback (wr_onehot) and once for issue (inc vector).
- Counter array and stall logic live in the top module.

## Test plan
- Reset, then idle: busy = 0, err = 0, stall = 0, wr_onehot = 0.
- wb_en = 1, wb_addr = 3 → wr_onehot = 0x00000008. wb_addr = 31 → wr_onehot = 0, err unchanged.
- Issue dst = 5, next cycle issue src_a = 5 → stall = 1, busy[5] = 1. Writeback 5 → busy[5] clears the following cycle. Re-issue → stall = 0.
- Three issues to dst = 7 (CNT_W = 2): all accepted, count = 3. Fourth → stall = 1. One writeback → fourth is accepted next cycle.
- Same-cycle issue dst = 9 and writeback 9 with count 1 → count stays 1, busy[9] = 1.
- Writeback to register 2 with count 0 → err = 1 and stays 1 until reset. Assert reset while counts are nonzero → all busy = 0 and err = 0 after the edge.
- With SCOREBOARD_BYPASS_EN: count[4] = 1, wb 4 and issue src_b = 4 in the same cycle → stall = 0. Without the macro → stall = 1.

Source files
------------

// File: rtl/reg_scoreboard_decoder_pkg.sv
// Shared constants and types for the register-file write decoder/scoreboard.
// Defaults: 5-bit register address, 2-bit pending counters, zero reg = 31.
package regfile_pkg;

   localparam int ADDR_W   = 5;
   localparam int CNT_W    = 2;
   localparam int ZERO_REG = (2**ADDR_W) - 1;

   typedef logic [CNT_W-1:0]       pend_cnt_t;
   typedef logic [(2**ADDR_W)-1:0] reg_vec_t;

endpackage

// File: rtl/reg_scoreboard_decoder_if.sv
// Writeback/issue bundle between pipeline control and the scoreboard.
// master drives wb_*/iss_*; slave returns wr_onehot, stall, busy, err.
interface reg_scoreboard_decoder_if #(
   parameter int ADDR_W = regfile_pkg::ADDR_W
) ();

   localparam int NREGS = 2**ADDR_W;

   logic              wb_en;
   logic [ADDR_W-1:0] wb_addr;
   logic [NREGS-1:0]  wr_onehot;
   logic              iss_en;
   logic [ADDR_W-1:0] iss_dst;
   logic [ADDR_W-1:0] iss_src_a;
   logic [ADDR_W-1:0] iss_src_b;
   logic              stall;
   logic [NREGS-1:0]  busy;
   logic              err;

   modport master (
      output wb_en, wb_addr,
      output iss_en, iss_dst, iss_src_a, iss_src_b,
      input  wr_onehot, stall, busy, err
   );

   modport slave (
      input  wb_en, wb_addr,
      input  iss_en, iss_dst, iss_src_a, iss_src_b,
      output wr_onehot, stall, busy, err
   );

endinterface

// File: rtl/reg_scoreboard_decoder_dec.sv
// decoder_param: binary address to one-hot, gated by enable (combinational).
// Ports: en_i, addr_i[ADDR_W] in; onehot_o[2**ADDR_W] out.
module decoder_param #(
   parameter int ADDR_W = regfile_pkg::ADDR_W
) (
   input  logic                   en_i,
   input  logic [ADDR_W-1:0]      addr_i,
   output logic [(2**ADDR_W)-1:0] onehot_o
);

   always_comb begin
      onehot_o         = '0;
      onehot_o[addr_i] = en_i;
   end

endmodule

// File: rtl/reg_scoreboard_decoder.sv
// Write-port decoder plus per-register pending-write scoreboard and stall.
// Ports: clk, reset (sync, active-high), bus (slave modport of the _if).
// Optional SCOREBOARD_BYPASS_EN: let a same-cycle writeback clear hazards.
module reg_scoreboard_decoder #(
   parameter int ADDR_W   = regfile_pkg::ADDR_W,
   parameter int CNT_W    = regfile_pkg::CNT_W,
   parameter int ZERO_REG = (2**ADDR_W) - 1
) (
   input logic                     clk,
   input logic                     reset,
   reg_scoreboard_decoder_if.slave bus
);

   import regfile_pkg::*;

   localparam int NREGS = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] ZERO_A  = ADDR_W'(ZERO_REG);
   localparam logic [CNT_W-1:0]  CNT_MAX = '1;
   localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
   localparam logic [NREGS-1:0]  ZMASK   =
      {{(NREGS-1){1'b0}}, 1'b1} << ZERO_REG;

   logic [CNT_W-1:0] cnt_q [NREGS];
   logic [CNT_W-1:0] cnt_d [NREGS];
   logic             err_q, err_d;

   logic [NREGS-1:0] wb_dec, iss_dec;
   logic [NREGS-1:0] inc, dec;
   logic [CNT_W-1:0] cnt_a, cnt_b, cnt_dst;
   logic             hazard_a, hazard_b, full_dst;
   logic             iss_fire;

   decoder_param #(.ADDR_W(ADDR_W)) u_wb_dec (
      .en_i     (bus.wb_en),
      .addr_i   (bus.wb_addr),
      .onehot_o (wb_dec)
   );

   decoder_param #(.ADDR_W(ADDR_W)) u_iss_dec (
      .en_i     (iss_fire),
      .addr_i   (bus.iss_dst),
      .onehot_o (iss_dec)
   );

   // The zero register never gets a write enable nor a pending count.
   assign dec           = wb_dec & ~ZMASK;
   assign inc           = iss_dec & ~ZMASK;
   assign bus.wr_onehot = dec;

   assign cnt_a   = cnt_q[bus.iss_src_a];
   assign cnt_b   = cnt_q[bus.iss_src_b];
   assign cnt_dst = cnt_q[bus.iss_dst];

`ifdef SCOREBOARD_BYPASS_EN
   // Last outstanding write retiring now: write-through forwards the data.
   logic byp_a, byp_b, byp_dst;
   assign byp_a   = bus.wb_en && bus.wb_addr == bus.iss_src_a
                    && cnt_a == CNT_ONE;
   assign byp_b   = bus.wb_en && bus.wb_addr == bus.iss_src_b
                    && cnt_b == CNT_ONE;
   assign byp_dst = bus.wb_en && bus.wb_addr == bus.iss_dst;
`else
   logic byp_a, byp_b, byp_dst;
   assign byp_a   = 1'b0;
   assign byp_b   = 1'b0;
   assign byp_dst = 1'b0;
`endif

   assign hazard_a = bus.iss_src_a != ZERO_A && cnt_a != '0 && !byp_a;
   assign hazard_b = bus.iss_src_b != ZERO_A && cnt_b != '0 && !byp_b;
   assign full_dst = bus.iss_dst != ZERO_A && cnt_dst == CNT_MAX
                     && !byp_dst;

   assign bus.stall = bus.iss_en && (hazard_a || hazard_b || full_dst);
   assign iss_fire  = bus.iss_en && !bus.stall;

   always_comb begin
      err_d = err_q;
      for (int i = 0; i < NREGS; i++) begin
         cnt_d[i] = cnt_q[i];
         if (inc[i] && !dec[i]) begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
         end else if (dec[i] && !inc[i]) begin
            if (cnt_q[i] == '0) err_d = 1'b1;
            else                cnt_d[i] = cnt_q[i] - CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) cnt_q[i] <= '0;
         err_q <= 1'b0;
      end else begin
         for (int i = 0; i < NREGS; i++) cnt_q[i] <= cnt_d[i];
         err_q <= err_d;
      end
   end

   always_comb begin
      bus.busy = '0;
      for (int i = 0; i < NREGS; i++) bus.busy[i] = |cnt_q[i];
   end

   assign bus.err = err_q;

endmodule
